// File: rtl/fpu_defs.sv
// Shared FP32 definitions for the FPU pipeline stages: packed binary32
// layout, format constants and the normalize/round stage state encoding.
package fpu_defs;

  localparam int man_bits = 23;
  localparam int exp_bias = 127;
  // All-ones biased exponent: reserved for infinities.
  localparam int exp_max  = 2 * exp_bias + 1;

  typedef struct packed {
    logic                s;
    logic [7:0]          e;
    logic [man_bits-1:0] m;
  } fp_num;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  // Assemble a binary32 word from its fields.
  function automatic fp_num fp_pack(input logic s, input logic [7:0] e,
                                    input logic [man_bits-1:0] m);
    fp_num r;
    r.s = s;
    r.e = e;
    r.m = m;
    return r;
  endfunction

endpackage

// File: rtl/fpu_rne_round.sv
// Combinational round-to-nearest-even incrementer for a 24-bit significand.
// A carry out means the significand overflowed to 2^24; the returned
// significand is then 2^23 and the caller bumps its exponent by one.
module fpu_rne_round #(
  parameter int SIG_W = 24
) (
  input  logic [SIG_W-1:0] i_sig,
  input  logic             i_guard,
  input  logic             i_sticky,
  output logic [SIG_W-1:0] o_sig,
  output logic             o_carry,
  output logic             o_inexact
);

  logic             w_inc;
  logic [SIG_W:0]   w_sum;

  // Round up on guard when above the halfway point or on a tie with odd lsb.
  always_comb begin
    w_inc     = i_guard & (i_sticky | i_sig[0]);
    w_sum     = {1'b0, i_sig} + {{SIG_W{1'b0}}, w_inc};
    o_carry   = w_sum[SIG_W];
    o_inexact = i_guard | i_sticky;
    if (w_sum[SIG_W]) begin
      o_sig = {1'b1, {(SIG_W-1){1'b0}}};
    end else begin
      o_sig = w_sum[SIG_W-1:0];
    end
  end

endmodule

// File: rtl/fpu_mul_normround.sv
// FP32 multiply normalize-and-round stage. Takes the raw 48-bit significand
// product and exponent sum, normalizes one bit per cycle (with denormalizing
// right shifts for tiny results), rounds to nearest-even and returns a packed
// binary32 with overflow/underflow/inexact flags over valid/ready.
module fpu_mul_normround
  import fpu_defs::*;
#(
  parameter int EXP_W    = 11,
  parameter int PROD_W   = 48,
  parameter int MAX_ITER = 50
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_sign,
  input  logic signed [EXP_W-1:0] i_exp,
  input  logic [PROD_W-1:0]       i_prod,
  input  logic                    i_zero,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [31:0]             o_result,
  output logic                    o_ovf,
  output logic                    o_unf,
  output logic                    o_inexact
);

  localparam int SIG_W  = man_bits + 1;
  localparam int HI     = PROD_W - 2;        // hidden-bit position of a normal
  localparam int GRD    = HI - SIG_W;        // guard bit position
  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam logic signed [EXP_W-1:0] E_ONE = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(exp_max);
  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

  // True while the working value still needs a normalization step.
  function automatic logic need_shift(input logic [PROD_W-1:0] m,
                                      input logic signed [EXP_W-1:0] e);
    return m[PROD_W-1] | (e < E_ONE) | (~m[HI] & (e > E_ONE));
  endfunction

  fsm_state_t               r_state;
  logic                     r_sign;
  logic signed [EXP_W-1:0]  r_e;
  logic [PROD_W-1:0]        r_m;
  logic                     r_sticky;
  logic [ITER_W-1:0]        r_iter;
  logic                     r_ready;
  logic                     r_valid;
  fp_num                    r_result;
  logic                     r_ovf;
  logic                     r_unf;
  logic                     r_inexact;

  logic [PROD_W-1:0]        w_m_sh;
  logic signed [EXP_W-1:0]  w_e_sh;
  logic                     w_sticky_sh;
  logic [SIG_W-1:0]         w_sig_pre;
  logic [SIG_W-1:0]         w_sig_rnd;
  logic                     w_sticky_all;
  logic                     w_carry;
  logic                     w_inexact;
  logic signed [EXP_W-1:0]  w_e_rnd;
  logic                     w_tiny;
  fp_num                    w_pack;
  logic                     w_ovf;
  logic                     w_unf;
  logic                     w_inx;

  // One normalization step: right shift (overflowed or too tiny) or left shift.
  always_comb begin
    w_m_sh      = r_m;
    w_e_sh      = r_e;
    w_sticky_sh = r_sticky;
    if (r_m[PROD_W-1] || (r_e < E_ONE)) begin
      w_m_sh      = {1'b0, r_m[PROD_W-1:1]};
      w_sticky_sh = r_sticky | r_m[0];
      w_e_sh      = r_e + E_ONE;
    end else begin
      w_m_sh      = {r_m[PROD_W-2:0], 1'b0};
      w_e_sh      = r_e - E_ONE;
    end
  end

  assign w_sig_pre    = r_m[HI -: SIG_W];
  assign w_sticky_all = (|r_m[GRD-1:0]) | r_sticky;

  fpu_rne_round #(.SIG_W(SIG_W)) u_rnd (
    .i_sig     (w_sig_pre),
    .i_guard   (r_m[GRD]),
    .i_sticky  (w_sticky_all),
    .o_sig     (w_sig_rnd),
    .o_carry   (w_carry),
    .o_inexact (w_inexact)
  );

  // Rounded exponent and packing into binary32 with IEEE flags.
  always_comb begin
    w_e_rnd = w_carry ? (r_e + E_ONE) : r_e;
    w_tiny  = ~r_m[HI] | (r_e < E_ONE);
    w_ovf   = 1'b0;
    w_unf   = w_tiny & w_inexact;
    w_inx   = w_inexact;
    w_pack  = fp_pack(r_sign, 8'h00, w_sig_rnd[man_bits-1:0]);
    if (w_e_rnd >= E_MAX) begin
      w_pack = fp_pack(r_sign, 8'hFF, {man_bits{1'b0}});
      w_ovf  = 1'b1;
      w_unf  = 1'b0;
      w_inx  = 1'b1;
    end else if (w_sig_rnd[SIG_W-1] && (w_e_rnd >= E_ONE)) begin
      w_pack = fp_pack(r_sign, w_e_rnd[7:0], w_sig_rnd[man_bits-1:0]);
    end else begin
      w_pack = fp_pack(r_sign, 8'h00, w_sig_rnd[man_bits-1:0]);
    end
  end

  // Control FSM with working registers and registered handshake/result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_sign    <= 1'b0;
      r_e       <= '0;
      r_m       <= '0;
      r_sticky  <= 1'b0;
      r_iter    <= '0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_sign   <= i_sign;
            r_e      <= i_exp;
            r_m      <= i_prod;
            r_sticky <= 1'b0;
            r_iter   <= '0;
            r_ready  <= 1'b0;
            if (i_zero || (i_prod == '0)) begin
              r_result  <= fp_pack(i_sign, 8'h00, {man_bits{1'b0}});
              r_ovf     <= 1'b0;
              r_unf     <= 1'b0;
              r_inexact <= 1'b0;
              r_valid   <= 1'b1;
              r_state   <= ST_DONE;
            end else if (need_shift(i_prod, i_exp)) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_ROUND;
            end
          end
        end
        ST_SHIFT: begin
          r_m      <= w_m_sh;
          r_e      <= w_e_sh;
          r_sticky <= w_sticky_sh;
          r_iter   <= r_iter + ITER_ONE;
          // The iteration cap guarantees exit even for absurd exponents.
          if (!need_shift(w_m_sh, w_e_sh) || (r_iter == ITER_LAST)) begin
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_result  <= w_pack;
          r_ovf     <= w_ovf;
          r_unf     <= w_unf;
          r_inexact <= w_inx;
          r_valid   <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_valid;
  assign o_result  = r_result;
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;
  assign o_inexact = r_inexact;

endmodule

// File: tb/tb_fpu_mul_normround.sv
// Directed bench for fpu_mul_normround: table of hand-computed vectors plus
// hand-written sequences for output hold, busy-ignore and mid-op reset.
module tb_fpu_mul_normround;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_valid;
  logic               o_ready;
  logic               i_sign;
  logic signed [10:0] i_exp;
  logic [47:0]        i_prod;
  logic               i_zero;
  logic               o_valid;
  logic               i_ready;
  logic [31:0]        o_result;
  logic               o_ovf;
  logic               o_unf;
  logic               o_inexact;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic               sign;
    logic signed [10:0] exp;
    logic [47:0]        prod;
    logic               zero;
    logic [31:0]        res;
    logic [2:0]         flags;   // {ovf, unf, inexact}
    int                 lat;
    string              name;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  fpu_mul_normround dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_sign    (i_sign),
    .i_exp     (i_exp),
    .i_prod    (i_prod),
    .i_zero    (i_zero),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_ovf     (o_ovf),
    .o_unf     (o_unf),
    .o_inexact (o_inexact)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    i_sign  = v.sign;
    i_exp   = v.exp;
    i_prod  = v.prod;
    i_zero  = v.zero;
    i_valid = 1'b1;
    i_ready = 1'b0;
    check({v.name, "_ready_idle"}, {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    cyc = 1;
    check({v.name, "_ready_busy"}, {31'd0, o_ready}, 32'd0);
    while (!o_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({v.name, "_latency"}, cyc, v.lat);
    check({v.name, "_result"}, o_result, v.res);
    check({v.name, "_flags"}, {29'd0, o_ovf, o_unf, o_inexact}, {29'd0, v.flags});
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check({v.name, "_handshake"}, {30'd0, o_valid, o_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{1'b0,  11'sd128, 48'h600000000000, 1'b0, 32'h40400000, 3'b000, 2,  "m1p5x2"};
    vecs[1]  = '{1'b0,  11'sd127, 48'h900000000000, 1'b0, 32'h40100000, 3'b000, 3,  "m1p5x1p5"};
    vecs[2]  = '{1'b0,  11'sd127, 48'h400000C00000, 1'b0, 32'h3F800002, 3'b001, 2,  "tie_odd"};
    vecs[3]  = '{1'b0,  11'sd127, 48'h400000400000, 1'b0, 32'h3F800000, 3'b001, 2,  "tie_even"};
    vecs[4]  = '{1'b0,  11'sd300, 48'h400000000000, 1'b0, 32'h7F800000, 3'b101, 2,  "ovf_pos"};
    vecs[5]  = '{1'b1,  11'sd300, 48'h400000000000, 1'b0, 32'hFF800000, 3'b101, 2,  "ovf_neg"};
    vecs[6]  = '{1'b0, -11'sd20,  48'h400000000001, 1'b0, 32'h00000004, 3'b011, 23, "subnorm"};
    vecs[7]  = '{1'b1,  11'sd127, 48'h400000000000, 1'b1, 32'h80000000, 3'b000, 1,  "zero_neg"};
    vecs[8]  = '{1'b0,  11'sd127, 48'h000000000000, 1'b0, 32'h00000000, 3'b000, 1,  "prod_zero"};
    vecs[9]  = '{1'b0,  11'sd127, 48'h7FFFFFC00000, 1'b0, 32'h40000000, 3'b001, 2,  "carry_out"};
    vecs[10] = '{1'b0,  11'sd128, 48'h200000000000, 1'b0, 32'h3F800000, 3'b000, 3,  "left_shift"};
    vecs[11] = '{1'b0,  11'sd254, 48'h7FFFFFC00000, 1'b0, 32'h7F800000, 3'b101, 2,  "ovf_by_round"};
    vecs[12] = '{1'b0,  11'sd1,   48'h3FFFFFC00000, 1'b0, 32'h00800000, 3'b011, 2,  "sub_to_norm"};
    vecs[13] = '{1'b1,  11'sd100, 48'h400000000000, 1'b0, 32'hB2000000, 3'b000, 2,  "neg_normal"};
    vecs[14] = '{1'b0,  11'sd127, 48'h400000600000, 1'b0, 32'h3F800001, 3'b001, 2,  "round_up"};
    vecs[15] = '{1'b0, -11'sd100, 48'h400000000000, 1'b0, 32'h00000000, 3'b011, 52, "iter_cap"};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_sign  = 1'b0;
    i_exp   = '0;
    i_prod  = '0;
    i_zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hs", {30'd0, o_valid, o_ready}, 32'd1);
    check("reset_result", o_result, 32'd0);
    check("reset_flags", {29'd0, o_ovf, o_unf, o_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i]);
    end

    // Result held while the consumer stalls; new input ignored while busy.
    @(negedge clk);
    i_sign  = 1'b1;
    i_zero  = 1'b1;
    i_prod  = 48'h400000000000;
    i_exp   = 11'sd127;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_sign  = 1'b0;
    i_zero  = 1'b0;
    check("stall_valid0", {31'd0, o_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stall_result", o_result, 32'h80000000);
      check("stall_hs", {30'd0, o_valid, o_ready}, 32'd2);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check("stall_release", {30'd0, o_valid, o_ready}, 32'd1);

    // Reset during a long SHIFT sequence aborts the operation.
    @(negedge clk);
    i_sign  = 1'b0;
    i_exp   = -11'sd20;
    i_prod  = 48'h400000000001;
    i_zero  = 1'b0;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", {30'd0, o_valid, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_mid_edge", {30'd0, o_valid, o_ready}, 32'd1);
    check("rst_mid_result", o_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (!o_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rst_op_lost", {31'd0, o_valid}, 32'd0);

    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_mul_normround.md
# fpu_mul_normround

Sequential normalize-and-round stage directly downstream of the combinational FP32 multiply datapath. It accepts a raw product (sign, biased exponent sum, full 48-bit significand product) and normalizes it iteratively, one bit per cycle, to the IEEE-754 binary32 format. It rounds to nearest-even and returns a packed binary32 result with status flags over a valid/ready handshake. It replaces the truncating, flag-less shift-down loop of the multiply function and is the last stage before results return to the FPU register side.

## Interface
- EXP_W, 11: internal signed exponent width (covers -300..+400)
- PROD_W, 48: significand product width (24×24)
- MAX_ITER, 50: shift-iteration cap before forced exit
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_valid  in  1  product presented
- o_ready  out  1  stage can accept; high only in IDLE
- i_sign  in  1  product sign (X.s ^ Y.s)
- i_exp  in  EXP_W  signed biased exponent, X.e + Y.e − 127 (input exponent 0 already remapped to 1 upstream)
- i_prod  in  PROD_W  product of 24-bit significands; value = i_prod·2^-46·2^(i_exp−127)
- i_zero  in  1  either operand zero
- o_valid  out  1  result held
- i_ready  in  1  consumer accepts
- o_result  out  32  packed {s, e[7:0], m[22:0]}
- o_ovf, o_unf, o_inexact  out  1 each  IEEE flags for o_result

## Operation
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE: o_ready=1. On i_valid: latch sign/exp/prod, clear sticky and iter counter. If i_zero or i_prod==0, go to DONE with ±0 and no flags. Otherwise go to SHIFT.
- SHIFT: one action per cycle, evaluated in priority order:
  - m[47]=1: m>>=1, sticky|=shifted bit, e+=1.
  - e<1: m>>=1 with sticky, e+=1 (denormalize).
  - m[46]=0 and e>1: m<<=1, e−=1.
  - Otherwise go to ROUND.
  - If the iter counter reaches MAX_ITER, go to ROUND regardless.
- ROUND: sig=m[46:23], guard=m[22], sticky_all=|m[21:0] | sticky.
  - Round-nearest-even: increment sig when guard & (sticky_all | sig[0]).
  - Carry out to 2^24 → sig=2^23, e+=1.
  - A subnormal that rounds up to 2^23 becomes normal with e=1.
  - inexact = guard | sticky_all.
- Pack:
  - e≥255: ±inf (0x7F800000 | s<<31), o_ovf=1, o_inexact=1.
  - sig[23]=0: exponent field 0, subnormal.
  - Otherwise exponent field = e[7:0], mantissa = sig[22:0].
  - o_unf = result tiny (before rounding) & inexact.
- DONE: o_valid=1, outputs stable until i_ready, then return to IDLE.

## Timing
- Reset: state=IDLE; o_ready=1; o_valid=0; o_result=0; all flags 0.
- Latency, accept edge to o_valid: 1 (load) + N shift cycles (0..MAX_ITER) + 1 (round).
  - Normal×normal product: N ≤ 1, so 2–3 cycles.
  - Zero: 1 cycle.
- One operation in flight. o_ready=0 from accept until the DONE handshake completes, so there is no same-cycle accept on DONE exit.
- Outputs are registered. o_result and flags change only on the ROUND→DONE transition.
- i_valid while o_ready=0 is ignored; the upstream stage holds its data.
- Reset asserted mid-operation aborts immediately to reset values, and the in-flight op is lost.

## Structure
- Shared package fpu_defs: the fp_num struct (s, e[7:0], m[22:0]), man_bits=23, exp_bias=127, exp_max=255, and a state enum type.
- One sub-module, fpu_rne_round: a combinational 24-bit RNE incrementer with carry-out and inexact. It is reused by the adder's rounding stage.
- The counter, shifter and FSM stay in the top module.

## Test plan
- 1.5×2.0: i_exp=128, i_prod=0x600000000000 → result 0x40400000, 2 cycles, no flags.
- 1.5×1.5: i_prod=0x900000000000 (m[47]=1), i_exp=127 → 0x40100000 (2.25), 3 cycles.
- Tie-to-even: i_prod with sig odd, guard=1, rest 0 → sig+1, inexact=1. The same case with sig even → unchanged.
- i_exp=300 → 0x7F800000, o_ovf=1, o_inexact=1. With i_sign=1 → 0xFF800000.
- i_exp=−20, i_prod=0x400000000001 → subnormal or zero, o_unf=1, o_inexact=1, terminates within MAX_ITER.
- i_zero=1, i_sign=1 → 0x80000000 in 1 cycle. Holding i_ready=0 for 5 cycles keeps outputs stable. Reset pulsed mid-SHIFT → o_valid=0, o_ready=1 on the next edge.
